// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared state encoding and word geometry for the program loader
package program_loader_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int WORD_BITS      = BYTES_PER_WORD * 8;
   localparam int BYTE_IDX_W     = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte stream input and program-memory write port of the loader
interface program_loader_if #(
   parameter int DATA_WIDTH = 32
);
   logic [7:0]            byte_in;
   logic                  byte_valid;
   logic                  byte_ready;
   logic                  WriteEnable;
   logic [DATA_WIDTH-1:0] WriteAddress;
   logic [DATA_WIDTH-1:0] WriteData;

   modport master (
      input  byte_in,
      input  byte_valid,
      output byte_ready,
      output WriteEnable,
      output WriteAddress,
      output WriteData
   );

   modport slave (
      output byte_in,
      output byte_valid,
      input  byte_ready,
      input  WriteEnable,
      input  WriteAddress,
      input  WriteData
   );
endinterface

// File: rtl/program_loader_word_assembler.sv
// rtl/program_loader_word_assembler.sv - packs accepted bytes little-endian into one word
module word_assembler
   import program_loader_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 byte_en,
   input  logic [7:0]           byte_in,
   output logic [WORD_BITS-1:0] word,
   output logic                 word_done
);

   logic [BYTE_IDX_W-1:0] idx_q, idx_d;
   logic [WORD_BITS-1:0]  word_q, word_d;

   always_comb begin
      idx_d     = idx_q;
      word_d    = word_q;
      word_done = 1'b0;
      if (clear) begin
         idx_d  = '0;
         word_d = '0;
      end else if (byte_en) begin
         word_d[{idx_q, 3'b000} +: 8] = byte_in;
         idx_d     = idx_q + BYTE_IDX_W'(1);
         word_done = (idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q  <= '0;
         word_q <= '0;
      end else begin
         idx_q  <= idx_d;
         word_q <= word_d;
      end
   end

   assign word = word_q;

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - fills program memory from a byte stream while holding the core in reset
module program_loader
   import program_loader_pkg::*;
#(
   parameter int  MEMORY_DEPTH = 32,
   parameter int  DATA_WIDTH   = 32,
   localparam int CW           = $clog2(MEMORY_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CW-1:0]    word_count,
   program_loader_if.master bus,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic             cpu_hold
);

   localparam logic [CW-1:0] DEPTH_C = CW'(MEMORY_DEPTH);

   state_t                state_q, state_d;
   logic [CW-1:0]         words_left_q, words_left_d;
   logic [DATA_WIDTH-1:0] addr_q, addr_d;
   logic                  error_q, error_d;

   logic                  byte_ready;
   logic                  byte_fire;
   logic                  asm_clear;
   logic                  word_done;
   logic [WORD_BITS-1:0]  word;

   assign byte_fire = bus.byte_valid & byte_ready;

   word_assembler u_word_assembler (
      .clk       (clk),
      .reset     (reset),
      .clear     (asm_clear),
      .byte_en   (byte_fire),
      .byte_in   (bus.byte_in),
      .word      (word),
      .word_done (word_done)
   );

   always_comb begin
      state_d      = state_q;
      words_left_d = words_left_q;
      addr_d       = addr_q;
      error_d      = error_q;
      asm_clear    = 1'b0;
      byte_ready   = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      bus.WriteEnable = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (word_count == '0) begin
                  error_d = 1'b0;
                  state_d = DONE;
               end else if (word_count > DEPTH_C) begin
                  error_d = 1'b1;
               end else begin
                  error_d      = 1'b0;
                  words_left_d = word_count;
                  addr_d       = '0;
                  asm_clear    = 1'b1;
                  state_d      = RECV;
               end
            end
         end
         RECV: begin
            busy       = 1'b1;
            byte_ready = 1'b1;
            if (word_done) begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            busy            = 1'b1;
            bus.WriteEnable = 1'b1;
            words_left_d    = words_left_q - CW'(1);
            // The final word leaves the address on itself so it never points past the memory.
            if (words_left_q == CW'(1)) begin
               state_d = DONE;
            end else begin
               addr_d  = addr_q + DATA_WIDTH'(BYTES_PER_WORD);
               state_d = RECV;
            end
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         words_left_q <= '0;
         addr_q       <= '0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         words_left_q <= words_left_d;
         addr_q       <= addr_d;
         error_q      <= error_d;
      end
   end

   assign bus.byte_ready   = byte_ready;
   assign bus.WriteAddress = addr_q;
   assign bus.WriteData    = DATA_WIDTH'(word);
   assign error            = error_q;
   assign cpu_hold         = busy;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

   localparam int DEPTH = 32;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [CW-1:0] word_count;
   logic          busy, done, error, cpu_hold;

   int checks   = 0;
   int failures = 0;

   logic [7:0]  stim[$];
   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];

   program_loader_if #(.DATA_WIDTH(32)) bus ();

   program_loader #(.MEMORY_DEPTH(DEPTH), .DATA_WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .word_count (word_count),
      .bus        (bus),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .cpu_hold   (cpu_hold)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.WriteEnable === 1'b1) begin
         wr_addr.push_back(bus.WriteAddress);
         wr_data.push_back(bus.WriteData);
         checks++;
         if (bus.WriteAddress[1:0] !== 2'b00 || bus.WriteAddress > 32'h7C) begin
            failures++;
            $display("FAIL write_addr_range addr=%h required aligned and <= 0x7c", bus.WriteAddress);
         end
      end
   end

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
      stim.delete();
   endtask

   task automatic push_word(input logic [31:0] w);
      stim.push_back(w[7:0]);
      stim.push_back(w[15:8]);
      stim.push_back(w[23:16]);
      stim.push_back(w[31:24]);
   endtask

   task automatic do_start(input int count);
      @(negedge clk);
      start      = 1'b1;
      word_count = CW'(count);
      @(negedge clk);
      start      = 1'b0;
   endtask

   task automatic stream(input bit gaps);
      int idx = 0;
      int cyc = 0;
      bit v   = 1'b0;
      while (idx < stim.size() && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         v = gaps ? !v : 1'b1;
         bus.byte_valid = v;
         bus.byte_in    = stim[idx];
         if (v && bus.byte_ready === 1'b1) idx++;
      end
      @(negedge clk);
      bus.byte_valid = 1'b0;
      checks++;
      if (idx != stim.size()) begin
         failures++;
         $display("FAIL stream_accept got=%0d bytes required=%0d", idx, stim.size());
      end
   endtask

   task automatic wait_done(input string name);
      int cyc = 0;
      while (done !== 1'b1 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL %s_done_timeout done=%b required=1", name, done);
      end
      checks++;
      if (busy !== 1'b1 || cpu_hold !== 1'b1) begin
         failures++;
         $display("FAIL %s_busy_in_done busy=%b cpu_hold=%b required=1/1", name, busy, cpu_hold);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || cpu_hold !== 1'b0) begin
         failures++;
         $display("FAIL %s_after_done done=%b busy=%b cpu_hold=%b required=0/0/0", name, done, busy, cpu_hold);
      end
   endtask

   task automatic check_two_words(input string name);
      checks++;
      if (wr_addr.size() != 2) begin
         failures++;
         $display("FAIL %s_write_count got=%0d required=2", name, wr_addr.size());
      end else begin
         checks++;
         if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h20080013) begin
            failures++;
            $display("FAIL %s_word0 addr=%h data=%h required 0/20080013", name, wr_addr[0], wr_data[0]);
         end
         checks++;
         if (wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h24090001) begin
            failures++;
            $display("FAIL %s_word1 addr=%h data=%h required 4/24090001", name, wr_addr[1], wr_data[1]);
         end
      end
   endtask

   task automatic test_reset();
      reset          = 1'b1;
      start          = 1'b0;
      word_count     = '0;
      bus.byte_valid = 1'b0;
      bus.byte_in    = 8'h00;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.byte_ready !== 1'b0 || bus.WriteEnable !== 1'b0 || busy !== 1'b0 ||
          done !== 1'b0 || error !== 1'b0 || cpu_hold !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctrl ready=%b we=%b busy=%b done=%b error=%b hold=%b required all 0",
                  bus.byte_ready, bus.WriteEnable, busy, done, error, cpu_hold);
      end
      checks++;
      if (bus.WriteAddress !== 32'h0 || bus.WriteData !== 32'h0) begin
         failures++;
         $display("FAIL reset_bus addr=%h data=%h required 0/0", bus.WriteAddress, bus.WriteData);
      end
      reset = 1'b0;
   endtask

   task automatic load_two(input bit gaps, input string name);
      clear_log();
      push_word(32'h20080013);
      push_word(32'h24090001);
      do_start(2);
      checks++;
      if (busy !== 1'b1 || cpu_hold !== 1'b1 || bus.byte_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s_recv busy=%b hold=%b ready=%b required 1/1/1", name, busy, cpu_hold, bus.byte_ready);
      end
      stream(gaps);
      wait_done(name);
      check_two_words(name);
   endtask

   task automatic test_basic();
      load_two(1'b0, "basic");
   endtask

   task automatic test_gaps();
      load_two(1'b1, "gaps");
   endtask

   task automatic test_zero();
      clear_log();
      do_start(0);
      checks++;
      if (done !== 1'b1 || bus.byte_ready !== 1'b0) begin
         failures++;
         $display("FAIL zero_done done=%b ready=%b required 1/0", done, bus.byte_ready);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || bus.byte_ready !== 1'b0) begin
         failures++;
         $display("FAIL zero_after done=%b busy=%b ready=%b required 0/0/0", done, busy, bus.byte_ready);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (wr_addr.size() != 0) begin
         failures++;
         $display("FAIL zero_writes got=%0d required=0", wr_addr.size());
      end
   endtask

   task automatic test_error();
      clear_log();
      do_start(DEPTH + 1);
      checks++;
      if (error !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL err_set error=%b busy=%b required 1/0", error, busy);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (error !== 1'b1 || wr_addr.size() != 0) begin
         failures++;
         $display("FAIL err_sticky error=%b writes=%0d required 1/0", error, wr_addr.size());
      end
      push_word(32'hDDCCBBAA);
      do_start(1);
      checks++;
      if (error !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL err_clear error=%b busy=%b required 0/1", error, busy);
      end
      stream(1'b0);
      wait_done("err");
      checks++;
      if (wr_addr.size() != 1 || wr_addr[0] !== 32'h0 || wr_data[0] !== 32'hDDCCBBAA) begin
         failures++;
         $display("FAIL err_load writes=%0d addr=%h data=%h required 1/0/ddccbbaa",
                  wr_addr.size(), wr_addr.size() > 0 ? wr_addr[0] : 32'hx, wr_data.size() > 0 ? wr_data[0] : 32'hx);
      end
   endtask

   task automatic test_reset_mid();
      clear_log();
      stim.push_back(8'hEE);
      stim.push_back(8'hFF);
      do_start(1);
      stream(1'b0);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || cpu_hold !== 1'b0) begin
         failures++;
         $display("FAIL midreset_hold busy=%b cpu_hold=%b required 0/0", busy, cpu_hold);
      end
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (wr_addr.size() != 0) begin
         failures++;
         $display("FAIL midreset_writes got=%0d required=0", wr_addr.size());
      end
      clear_log();
      push_word(32'h44332211);
      do_start(1);
      stream(1'b0);
      wait_done("midreset");
      checks++;
      if (wr_addr.size() != 1 || wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h44332211) begin
         failures++;
         $display("FAIL midreset_fresh writes=%0d addr=%h data=%h required 1/0/44332211",
                  wr_addr.size(), wr_addr.size() > 0 ? wr_addr[0] : 32'hx, wr_data.size() > 0 ? wr_data[0] : 32'hx);
      end
   endtask

   task automatic test_full();
      clear_log();
      for (int i = 0; i < DEPTH; i++) push_word(32'(4 * i));
      do_start(DEPTH);
      @(negedge clk);
      start      = 1'b1;
      word_count = CW'(5);
      @(negedge clk);
      start      = 1'b0;
      stream(1'b0);
      wait_done("full");
      checks++;
      if (wr_addr.size() != DEPTH) begin
         failures++;
         $display("FAIL full_write_count got=%0d required=%0d", wr_addr.size(), DEPTH);
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (wr_addr[i] !== 32'(4 * i) || wr_data[i] !== 32'(4 * i)) begin
               failures++;
               $display("FAIL full_word%0d addr=%h data=%h required %h/%h",
                        i, wr_addr[i], wr_data[i], 32'(4 * i), 32'(4 * i));
            end
         end
         checks++;
         if (wr_addr[DEPTH-1] !== 32'h7C) begin
            failures++;
            $display("FAIL full_last_addr got=%h required=0000007c", wr_addr[DEPTH-1]);
         end
      end
      checks++;
      if (error !== 1'b0) begin
         failures++;
         $display("FAIL full_error got=%b required=0", error);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_zero();
      test_error();
      test_reset_mid();
      test_full();
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
